window_builder: RTL and testbench



---
 rtl/window_builder_if.sv | 28 ++
 rtl/window_builder.sv | 140 ++++++++++++++
 tb/tb_window_builder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_builder_if.sv
// Pixel-in / window-out bundle between a raster pixel source, window_builder and neuron_unit.
interface window_builder_if;
  logic        de_in;
  logic        sof_in;
  logic [7:0]  pix_in;
  logic        de_out;
  logic [55:0] line_0_out;
  logic [55:0] line_1_out;
  logic [55:0] line_2_out;
  logic [55:0] line_3_out;
  logic [55:0] line_4_out;
  logic [55:0] line_5_out;
  logic [55:0] line_6_out;
  logic [9:0]  win_row;
  logic [9:0]  win_col;

  modport master (
    output de_in, sof_in, pix_in,
    input  de_out, line_0_out, line_1_out, line_2_out, line_3_out,
           line_4_out, line_5_out, line_6_out, win_row, win_col
  );

  modport slave (
    input  de_in, sof_in, pix_in,
    output de_out, line_0_out, line_1_out, line_2_out, line_3_out,
           line_4_out, line_5_out, line_6_out, win_row, win_col
  );
endinterface

// File: rtl/window_builder.sv
// Streaming 7x7 window generator: six chained row delay lines feed a 7x7 shift window,
// and every fully in-frame window is presented with a one-cycle de_out strobe.
module window_builder #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic             clk,
  input  logic             reset,
  window_builder_if.slave  bus
);

  localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_HEIGHT - 1);

  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [9:0]       cur_col_s, cur_row_s;
  logic             accept_s;
  logic             win_valid_s;
  logic [7:0]       tap_s [6];
  logic [7:0]       lb_q  [6][IMG_WIDTH];
  logic [6:0][55:0] win_q, win_d;
  logic             de_out_q;
  logic [6:0][55:0] line_q;
  logic [9:0]       win_row_q, win_col_q;

  assign accept_s = bus.de_in;

  // Position of the pixel being accepted (sof forces it to 0,0) and the counter advance.
  always_comb begin
    cur_col_s = col_q;
    cur_row_s = row_q;
    col_d     = col_q;
    row_d     = row_q;
    if (bus.sof_in) begin
      cur_col_s = 10'd0;
      cur_row_s = 10'd0;
    end else begin
      cur_col_s = col_q;
      cur_row_s = row_q;
    end
    if (accept_s) begin
      if (cur_col_s == COL_LAST) begin
        col_d = 10'd0;
        if (cur_row_s == ROW_LAST) begin
          row_d = 10'd0;
        end else begin
          row_d = cur_row_s + 10'd1;
        end
      end else begin
        col_d = cur_col_s + 10'd1;
        row_d = cur_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    win_valid_s = accept_s && !bus.sof_in && (cur_row_s >= 10'd6) && (cur_col_s >= 10'd6);
  end

  // Position counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= 10'd0;
      row_q <= 10'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Row delay lines hold image data only; stale contents are masked by the validity rule.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_q[0][0] <= bus.pix_in;
      for (int k = 1; k < 6; k++) begin
        lb_q[k][0] <= lb_q[k-1][IMG_WIDTH-1];
      end
      for (int k = 0; k < 6; k++) begin
        for (int i = 1; i < IMG_WIDTH; i++) begin
          lb_q[k][i] <= lb_q[k][i-1];
        end
      end
    end
  end

  // Delay line k yields the pixel in the same column, k+1 rows above.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      tap_s[k] = lb_q[k][IMG_WIDTH-1];
    end
  end

  // Window row r is the packed 56-bit vector; the new column enters at bits [7:0].
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 6; r++) begin
      win_d[r] = {win_q[r][47:0], tap_s[5-r]};
    end
    win_d[6] = {win_q[6][47:0], bus.pix_in};
  end

  // Window shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
    end else if (accept_s) begin
      win_q <= win_d;
    end
  end

  // Registered window outputs; data and coordinates move only with a valid window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_out_q  <= 1'b0;
      line_q    <= '0;
      win_row_q <= 10'd0;
      win_col_q <= 10'd0;
    end else begin
      de_out_q <= win_valid_s;
      if (win_valid_s) begin
        line_q    <= win_d;
        win_row_q <= cur_row_s;
        win_col_q <= cur_col_s;
      end
    end
  end

  assign bus.de_out     = de_out_q;
  assign bus.line_0_out = line_q[0];
  assign bus.line_1_out = line_q[1];
  assign bus.line_2_out = line_q[2];
  assign bus.line_3_out = line_q[3];
  assign bus.line_4_out = line_q[4];
  assign bus.line_5_out = line_q[5];
  assign bus.line_6_out = line_q[6];
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_window_builder.sv
// Self-checking bench for window_builder on an 8x8 image: scoreboard of modelled windows
// plus a constant table of the four reference windows.
module tb_window_builder;
  localparam int W = 8;
  localparam int H = 8;

  typedef struct {
    logic [9:0]       row;
    logic [9:0]       col;
    logic [6:0][55:0] lines;
    int               cyc;
  } sb_t;

  typedef struct {
    logic [9:0]  row;
    logic [9:0]  col;
    logic [55:0] l0;
    logic [55:0] l6;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   cap_en = 1'b0;

  vec_t table_v [4];
  sb_t  sb_q [$];
  vec_t cap_q [$];

  logic [6:0][55:0] out_lines;
  logic [6:0][55:0] last_lines;
  logic [9:0]       last_row;
  logic [9:0]       last_col;

  window_builder_if bus ();

  window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign out_lines = {bus.line_6_out, bus.line_5_out, bus.line_4_out, bus.line_3_out,
                      bus.line_2_out, bus.line_1_out, bus.line_0_out};

  function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] off);
    return off + 8'(r * 16 + c);
  endfunction

  // Row k holds image row r-6+k, columns c-6..c with the oldest in the top byte.
  function automatic logic [6:0][55:0] exp_win(input int r, input int c, input logic [7:0] off);
    logic [6:0][55:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 7; j++) begin
        v[k][55-8*j -: 8] = pix(r - 6 + k, c - 6 + j, off);
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.de_in  = 1'b0;
    bus.sof_in = 1'b0;
    bus.pix_in = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input bit sof, input logic [7:0] off, input int r, input int c, input bit gaps);
    sb_t e;
    if (gaps && ($urandom_range(0, 1) == 1)) idle();
    @(posedge clk);
    #1;
    bus.de_in  = 1'b1;
    bus.sof_in = sof;
    bus.pix_in = pix(r, c, off);
    if (!sof && r >= 6 && c >= 6) begin
      e.row   = 10'(r);
      e.col   = 10'(c);
      e.lines = exp_win(r, c, off);
      e.cyc   = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  task automatic frame(input bit sof_first, input logic [7:0] off, input int start, input int stop,
                       input bit gaps);
    for (int idx = start; idx < stop; idx++) begin
      send(sof_first && (idx == start), off, idx / W, idx % W, gaps);
    end
  endtask

  task automatic drain();
    repeat (4) idle();
    chk("scoreboard_drained", 512'(sb_q.size()), 512'd0);
    sb_q.delete();
  endtask

  task automatic check_table(input string tag);
    chk({tag, "_window_count"}, 512'(cap_q.size()), 512'd4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      chk($sformatf("%s_coord%0d", tag, i), {492'd0, cap_q[i].row, cap_q[i].col},
          {492'd0, table_v[i].row, table_v[i].col});
      chk($sformatf("%s_lines%0d", tag, i), {400'd0, cap_q[i].l0, cap_q[i].l6},
          {400'd0, table_v[i].l0, table_v[i].l6});
    end
    cap_q.delete();
  endtask

  // Monitor: pop the scoreboard on each strobe, otherwise require outputs to hold.
  initial begin
    sb_t  e;
    vec_t cv;
    last_lines = '0;
    last_row   = 10'd0;
    last_col   = 10'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_lines = '0;
        last_row   = 10'd0;
        last_col   = 10'd0;
      end else if (bus.de_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_de_out: got window (%0d,%0d) expected none", bus.win_row, bus.win_col);
        end else begin
          e = sb_q.pop_front();
          chk("win_coord", {492'd0, bus.win_row, bus.win_col}, {492'd0, e.row, e.col});
          chk("win_lines", 512'(out_lines), 512'(e.lines));
          chk("win_latency", 512'(cyc), 512'(e.cyc));
        end
        if (cap_en) begin
          cv.row = bus.win_row;
          cv.col = bus.win_col;
          cv.l0  = bus.line_0_out;
          cv.l6  = bus.line_6_out;
          cap_q.push_back(cv);
        end
        last_lines = out_lines;
        last_row   = bus.win_row;
        last_col   = bus.win_col;
      end else begin
        chk("hold", {100'd0, out_lines, bus.win_row, bus.win_col},
            {100'd0, last_lines, last_row, last_col});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    table_v[0] = '{10'd6, 10'd6, 56'h00010203040506, 56'h60616263646566};
    table_v[1] = '{10'd6, 10'd7, 56'h01020304050607, 56'h61626364656667};
    table_v[2] = '{10'd7, 10'd6, 56'h10111213141516, 56'h70717273747576};
    table_v[3] = '{10'd7, 10'd7, 56'h11121314151617, 56'h71727374757677};

    bus.de_in  = 1'b0;
    bus.sof_in = 1'b0;
    bus.pix_in = 8'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_state", {99'd0, out_lines, bus.win_row, bus.win_col, bus.de_out}, 512'd0);

    cap_en = 1'b1;
    frame(1'b1, 8'h00, 0, W * H, 1'b0);
    drain();
    check_table("full_frame");

    frame(1'b1, 8'h00, 0, W * H, 1'b1);
    drain();
    check_table("gapped");
    cap_en = 1'b0;

    // sof at (3,2) restarts the frame with distinguishable pixel values
    frame(1'b1, 8'h00, 0, 3 * W + 2, 1'b0);
    frame(1'b1, 8'h80, 0, W * H, 1'b0);
    drain();

    // sof lands where the counters sit at (7,7): the pixel before still yields (7,6)
    frame(1'b1, 8'h00, 0, W * H - 1, 1'b0);
    frame(1'b1, 8'h80, 0, W * H, 1'b0);
    drain();

    frame(1'b1, 8'h00, 0, W * H, 1'b0);
    frame(1'b0, 8'h00, 0, W * H, 1'b0);
    drain();

    // asynchronous reset while the (6,6) window is being presented
    frame(1'b1, 8'h00, 0, 6 * W + 7, 1'b0);
    @(posedge clk);
    #1;
    bus.de_in  = 1'b0;
    bus.sof_in = 1'b0;
    chk("de_out_before_reset", 512'(bus.de_out), 512'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", {99'd0, out_lines, bus.win_row, bus.win_col, bus.de_out}, 512'd0);
    sb_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    cap_en = 1'b1;
    frame(1'b0, 8'h00, 0, W * H, 1'b0);
    drain();
    check_table("after_reset");
    cap_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
